// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch block.
//   XLEN / ILEN      : address and instruction widths
//   INSTR_NOP        : addi x0,x0,0; value shown on the output stage when empty after reset
//   PC_ALIGN_MASK    : clears the two low PC bits (word-aligned fetch only)
//   fetch_state_e    : BOOT / RUN / HALTED
//   fetch_rsp_t      : payload held by the output stage
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] INSTR_NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~64'h3;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_rsp_t;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: registered output stage between the ROM and decode.
//   clk, rst_n : clock, async active-low reset
//   load       : capture rsp_d and mark valid
//   flush      : drop the held entry (wins over load/drain)
//   drain      : entry consumed with no refill; clear valid
//   rsp_d      : incoming pc/instr
//   valid, rsp : held entry
// When none of load/flush/drain is asserted the entry holds (stall).
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       flush,
  input  logic       drain,
  input  fetch_rsp_t rsp_d,
  output logic       valid,
  output fetch_rsp_t rsp
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      rsp.pc    <= '0;
      rsp.instr <= INSTR_NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      rsp   <= rsp_d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for a combinational instruction ROM.
//   clk_i, rst_ni            : clock, async active-low reset
//   imem_addr_o/imem_data_i  : ROM address (= pc_q) and same-cycle read word
//   if_valid_o/if_instr_o/if_pc_o, id_ready_i : valid/ready output to decode
//   redirect_valid_i/redirect_pc_i : one-cycle flush + new PC (low 2 bits ignored)
//   halt_i                   : level; stop issuing fetches
//   halted_o                 : HALTED and output stage empty
//   fetch_count_o            : handshake counter
// Build option: define FETCH_PERF_EN to enable the handshake counter;
// otherwise fetch_count_o is tied to zero and no counter flops exist.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [ILEN-1:0] imem_data_i,
  output logic            if_valid_o,
  output logic [ILEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            id_ready_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            halted_o,
  output logic [XLEN-1:0] fetch_count_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            cap, drain, hs;
  fetch_rsp_t      rsp_d, rsp_q;

  // Capture only in RUN, never while halting or redirecting, and only when
  // the output stage is empty or being emptied this cycle.
  assign cap   = (state_q == RUN) && !halt_i && !redirect_valid_i &&
                 (!if_valid_o || id_ready_i);
  assign hs    = if_valid_o && id_ready_i;
  assign drain = hs && !cap;

  assign rsp_d.pc    = pc_q;
  assign rsp_d.instr = imem_data_i;

  fetch_out_reg u_out (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .load  (cap),
    .flush (redirect_valid_i),
    .drain (drain),
    .rsp_d (rsp_d),
    .valid (if_valid_o),
    .rsp   (rsp_q)
  );

  assign if_instr_o  = rsp_q.instr;
  assign if_pc_o     = rsp_q.pc;
  assign imem_addr_o = pc_q;
  assign halted_o    = (state_q == HALTED) && !if_valid_o;

  // FSM and PC. Redirect overrides everything, including BOOT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & PC_ALIGN_MASK;
    end else if (redirect_valid_i) begin
      state_q <= RUN;
      pc_q    <= redirect_pc_i & PC_ALIGN_MASK;
    end else begin
      if (cap) pc_q <= pc_q + XLEN'(PC_STEP);
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt_i)  state_q <= HALTED;
        HALTED:  if (!halt_i) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  cnt_q <= '0;
    else if (hs)  cnt_q <= cnt_q + 1'b1;
  end

  assign fetch_count_o = cnt_q;
`else
  assign fetch_count_o = '0;
`endif

endmodule
